data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing the single-ported data memory between the CPU
//  load/store stage (port 0) and a secondary master such as DMA/debug (port 1).
//  Each port runs a req/ack handshake; one memory transaction per grant.
//  Drives data_memory's address/write_data/mem_write/mem_read and captures read_data.
//  Flags out-of-range addresses.
// PARAMETERS
//  DATA_WIDTH     32  width of write/read data
//  ADDR_WIDTH     32  width of requester and memory addresses
//  MEM_ADDR_BITS   8  implemented word-index bits; higher address bits must be zero
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  rst_n          in   1     asynchronous reset, active low
//  p0_req         in   1     port 0 request; held high with stable fields until p0_ack
//  p0_we          in   1     port 0: 1 = write, 0 = read
//  p0_addr        in   ADDR  port 0 word address
//  p0_wdata       in   DATA  port 0 write data
//  p0_ack         out  1     port 0 one-cycle completion pulse
//  p0_err         out  1     port 0 out-of-range flag, valid with p0_ack
//  p0_rdata       out  DATA  port 0 read data, valid with p0_ack and held until next p0_ack
//  p1_*           -    -     identical set for port 1
//  mem_address    out  ADDR  to data_memory address
//  mem_write_data out  DATA  to data_memory write_data
//  mem_write      out  1     to data_memory mem_write
//  mem_read       out  1     to data_memory mem_read
//  mem_read_data  in   DATA  from data_memory read_data (combinational)
//  busy           out  1     high in ACCESS and RESP
// BEHAVIOUR
//  Reset, async on rst_n low: state = IDLE, last_grant = 1, all outputs 0, p*_rdata = 0.
//  FSM states:
//   IDLE:   sample p0_req and p1_req. If either is high, latch the winner's we/addr/wdata
//           and the winner id, then go to ACCESS. Otherwise stay in IDLE.
//   ACCESS: drive mem_address = latched addr and mem_write_data = latched wdata.
//           mem_write = we & in_range; mem_read = ~we & in_range. Memory writes on the
//           negedge inside this cycle. At the posedge, capture the winner's rdata:
//           mem_read_data if read & in_range, else 0 (writes also load 0).
//           Set ack/err for the winner. Go to RESP.
//   RESP:   winner's ack = 1 (err = ~in_range) for exactly this cycle. No arbitration.
//           Go to IDLE.
//  Fixed cost: 3 cycles per transaction (IDLE sample, ACCESS, RESP); peak 1 access per 3 cycles.
//  Arbitration: only one request -> grant it. Both requesting -> grant the port != last_grant.
//   last_grant updates on each grant. First tie after reset goes to port 0.
//  in_range = (addr[ADDR_WIDTH-1:MEM_ADDR_BITS] == 0).
//   Out of range: no memory strobe, rdata = 0, err = 1.
//  Outside ACCESS: mem_write = mem_read = 0, mem_address = mem_write_data = 0.
//  The loser keeps req high and is granted in the next IDLE, so no port waits more than
//   one transaction.
//  A req still high in RESP is treated as a new request in the following IDLE.
//  Reset asserted mid-ACCESS or mid-RESP: immediate return to IDLE and strobes drop.
//   No ack is issued. A write whose negedge has already occurred may have landed.
//  ack and err are registered. The non-winning port's ack/err stay 0. rdata changes only
//   on its own port's completion.
// TESTING
//  1. Reset: rst_n=0 mid-run -> all outputs 0 asynchronously; state IDLE; busy=0.
//  2. P0 write addr=5, data=0xDEADBEEF -> mem_write=1 for 1 cycle in ACCESS; p0_ack pulses
//     2 cycles after req sampled. Then p0 read addr=5 -> p0_rdata=0xDEADBEEF.
//  3. p0_req and p1_req both held for 4 transactions after reset -> grant order 0,1,0,1;
//     each ack single-cycle.
//  4. P1 read addr=0x100 (MEM_ADDR_BITS=8) -> mem_read and mem_write stay 0;
//     p1_ack=1, p1_err=1, p1_rdata=0.
//  5. P1 write addr=7 then rst_n pulsed low in ACCESS -> no p1_ack; FSM IDLE;
//     next p0 read arbitrates normally.
//  6. p0 holds req across RESP for 2 reads (addr 1, 2) -> back-to-back transactions
//     exactly 3 cycles apart.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : Bundle of the two requester handshakes and the data-memory
//               bus shared by data_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Port 0 (CPU load/store stage)
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_ack;
    logic                  p0_err;
    logic [DATA_WIDTH-1:0] p0_rdata;

    // Port 1 (DMA / debug)
    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ack;
    logic                  p1_err;
    logic [DATA_WIDTH-1:0] p1_rdata;

    // Data memory side
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_read_data;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data,
        output busy
    );

    // Requesters plus memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported data
//               memory. One memory transaction per grant, three cycles each
//               (IDLE sample, ACCESS, RESP). Out-of-range addresses are
//               flagged and never strobe the memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 8
) (
    input  wire                  clk,
    input  wire                  rst_n,
    data_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  win_q;
    logic                  we_q;
    logic                  in_range_q;

    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_write_data_q;
    logic                  mem_write_q;
    logic                  mem_read_q;
    logic                  busy_q;

    logic                  p0_ack_q;
    logic                  p0_err_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q;
    logic                  p1_ack_q;
    logic                  p1_err_q;
    logic [DATA_WIDTH-1:0] p1_rdata_q;

    logic                  grant_d;
    logic                  sel_we_d;
    logic [ADDR_WIDTH-1:0] sel_addr_d;
    logic [DATA_WIDTH-1:0] sel_wdata_d;
    logic                  in_range_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Round-robin pick and mux of the winning request's fields
    always_comb begin
        grant_d = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            // Tie: the port that did not win last time goes first
            grant_d = ~last_grant_q;
        end else if (bus.p1_req) begin
            grant_d = 1'b1;
        end
        sel_we_d    = grant_d ? bus.p1_we    : bus.p0_we;
        sel_addr_d  = grant_d ? bus.p1_addr  : bus.p0_addr;
        sel_wdata_d = grant_d ? bus.p1_wdata : bus.p0_wdata;
        in_range_d  = (sel_addr_d[ADDR_WIDTH-1:MEM_ADDR_BITS] == '0);
        // Only an in-range read returns memory data; writes and errors return 0
        rdata_d     = (!we_q && in_range_q) ? bus.mem_read_data : '0;
    end

    // Arbitration FSM with registered memory strobes and responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            last_grant_q     <= 1'b1;
            win_q            <= 1'b0;
            we_q             <= 1'b0;
            in_range_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            busy_q           <= 1'b0;
            p0_ack_q         <= 1'b0;
            p0_err_q         <= 1'b0;
            p0_rdata_q       <= '0;
            p1_ack_q         <= 1'b0;
            p1_err_q         <= 1'b0;
            p1_rdata_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        win_q            <= grant_d;
                        last_grant_q     <= grant_d;
                        we_q             <= sel_we_d;
                        in_range_q       <= in_range_d;
                        // The address/data registers double as the latched request
                        mem_address_q    <= sel_addr_d;
                        mem_write_data_q <= sel_wdata_d;
                        mem_write_q      <= sel_we_d & in_range_d;
                        mem_read_q       <= ~sel_we_d & in_range_d;
                        busy_q           <= 1'b1;
                        state_q          <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_address_q    <= '0;
                    mem_write_data_q <= '0;
                    mem_write_q      <= 1'b0;
                    mem_read_q       <= 1'b0;
                    if (win_q) begin
                        p1_rdata_q <= rdata_d;
                        p1_ack_q   <= 1'b1;
                        p1_err_q   <= ~in_range_q;
                    end else begin
                        p0_rdata_q <= rdata_d;
                        p0_ack_q   <= 1'b1;
                        p0_err_q   <= ~in_range_q;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    p0_ack_q <= 1'b0;
                    p0_err_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    p1_err_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_ack         = p0_ack_q;
    assign bus.p0_err         = p0_err_q;
    assign bus.p0_rdata       = p0_rdata_q;
    assign bus.p1_ack         = p1_ack_q;
    assign bus.p1_err         = p1_err_q;
    assign bus.p1_rdata       = p1_rdata_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Scoreboard bench for data_mem_arbiter with a 256-word memory
//               model written on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst_n;
    data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MEM_ADDR_BITS(8)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on falling edge
    logic [31:0] mem [256];
    assign bus.mem_read_data = mem[bus.mem_address[7:0]];
    always @(negedge clk) if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_write_data;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          wcount  = 0;
    int          rcount  = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          last_ack_cyc = 0;
    bit          prev_p0_ack = 0;
    bit          prev_p1_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ack(input bit port, input bit err, input logic [31:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack on port %0d expected none", port);
        end else begin
            e = sb.pop_front();
            chk("ack_port",  {31'd0, port}, {31'd0, e.port});
            chk("ack_err",   {31'd0, err},  {31'd0, e.err});
            chk("ack_rdata", rdata,         e.rdata);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_write) begin
                wcount++;
                last_waddr = bus.mem_address;
                last_wdata = bus.mem_write_data;
            end
            if (bus.mem_read) rcount++;
            if (bus.p0_ack && bus.p1_ack) begin
                n_tests++;
                n_fail++;
                $display("FAIL dual_ack: got both acks expected one");
            end
            if ((bus.p0_ack && prev_p0_ack) || (bus.p1_ack && prev_p1_ack)) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_width: got ack for 2 cycles expected 1");
            end
            if (bus.p0_ack) begin
                check_ack(1'b0, bus.p0_err, bus.p0_rdata);
                last_ack_cyc = cyc;
            end
            if (bus.p1_ack) begin
                check_ack(1'b1, bus.p1_err, bus.p1_rdata);
                last_ack_cyc = cyc;
            end
        end
        prev_p0_ack = bus.p0_ack;
        prev_p1_ack = bus.p1_ack;
    end

    // Issue one transaction on a port and wait for its ack (called at a falling edge)
    task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit exp_err,
                       input logic [31:0] exp_rd, input bit hold,
                       output int start_cyc, output int ack_cyc);
        bit done;
        exp_t e;
        e.port = port; e.err = exp_err; e.rdata = exp_rd;
        sb.push_back(e);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end else begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end
        start_cyc = cyc;
        ack_cyc   = cyc;
        done      = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (port ? bus.p1_ack : bus.p0_ack) begin
                done    = 1;
                ack_cyc = cyc;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack on port %0d expected ack", port);
        end
        if (!hold) begin
            if (port) bus.p1_req = 1'b0;
            else      bus.p0_req = 1'b0;
        end
    endtask

    initial begin
        int s0, a0, s1, a1, w0, r0, nack;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_p0_ack",   {31'd0, bus.p0_ack}, 32'd0);
        chk("rst_p1_ack",   {31'd0, bus.p1_ack}, 32'd0);
        chk("rst_p0_rdata", bus.p0_rdata, 32'd0);
        chk("rst_p1_rdata", bus.p1_rdata, 32'd0);
        chk("rst_strobes",  {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("rst_addr",     bus.mem_address, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // P0 write then read back
        w0 = wcount;
        txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, s0, a0);
        chk("wr_latency", a0 - s0, 32'd2);
        chk("wr_strobes", wcount - w0, 32'd1);
        chk("wr_addr",    last_waddr, 32'd5);
        chk("wr_data",    last_wdata, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, s0, a0);

        // P1 out-of-range read: no strobes, error, zero data; p0 data untouched
        @(negedge clk);
        w0 = wcount; r0 = rcount;
        txn(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0, 1'b0, s0, a0);
        chk("oor_wstrobe", wcount - w0, 32'd0);
        chk("oor_rstrobe", rcount - r0, 32'd0);
        chk("p0_rdata_held", bus.p0_rdata, 32'hDEAD_BEEF);

        // Both ports held after reset: grant order 0,1,0,1
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.port = i[0]; e.err = 1'b0; e.rdata = 32'hDEAD_BEEF;
            sb.push_back(e);
        end
        bus.p0_we = 0; bus.p0_addr = 32'd5;
        bus.p1_we = 0; bus.p1_addr = 32'd5;
        bus.p0_req = 1; bus.p1_req = 1;
        nack = 0;
        for (int k = 0; k < 40 && nack < 4; k++) begin
            @(negedge clk);
            if (bus.p0_ack || bus.p1_ack) nack++;
        end
        bus.p0_req = 0; bus.p1_req = 0;
        chk("rr_acks", nack, 32'd4);

        // P1 write aborted by reset during ACCESS
        @(negedge clk);
        bus.p1_we = 1; bus.p1_addr = 32'd7; bus.p1_wdata = 32'hCAFE_F00D; bus.p1_req = 1;
        @(posedge clk);
        #1;
        chk("abort_in_access", {31'd0, bus.mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_wstrobe", {31'd0, bus.mem_write}, 32'd0);
        chk("abort_busy",    {31'd0, bus.busy}, 32'd0);
        chk("abort_addr",    bus.mem_address, 32'd0);
        bus.p1_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_ack", {31'd0, bus.p1_ack}, 32'd0);
        chk("abort_mem7",   mem[7], 32'd0);
        txn(1'b0, 1'b0, 32'd7, 32'd0, 1'b0, 32'd0, 1'b0, s0, a0);

        // P0 holds req across RESP: back-to-back reads 3 cycles apart
        @(negedge clk);
        txn(1'b0, 1'b0, 32'd1, 32'd0, 1'b0, 32'h1111_1111, 1'b1, s0, a0);
        txn(1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 32'h2222_2222, 1'b0, s1, a1);
        chk("b2b_spacing", a1 - a0, 32'd3);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
